am_search: RTL and testbench
============================

// Module: am_search
// PURPOSE
//  Associative-memory search stage; consumes encoded_hv from the encoding stage when encoding_done fires.
//  Scores the latched query HV against CLASS_COUNT class HVs by sparse overlap, popcount(query & class).
//  Processes one DIMS_PER_CC-bit chunk of one class per cycle.
//  Returns the index and score of the best-matching class.
// PARAMETERS
//  HV_DIM       10000  hypervector width in bits; must be a multiple of DIMS_PER_CC
//  DIMS_PER_CC  500    bits scored per clock (chunk width)
//  CLASS_COUNT  26     number of class HVs
//  CHUNKS       HV_DIM/DIMS_PER_CC (derived), chunks per class
//  CLASS_W      $clog2(CLASS_COUNT) (derived); SCORE_W = $clog2(HV_DIM+1) (derived)
// PORTS
//  clk              in   1                    clock, all state on rising edge
//  nrst             in   1                    reset, synchronous, active-low
//  en               in   1                    clock enable; low freezes all state (outputs hold)
//  start_search     in   1                    request; wire to encoding_done
//  encoded_hv       in   HV_DIM               query HV; sampled only on accepted start
//  class_hvs        in   HV_DIM x CLASS_COUNT class HVs [0:CLASS_COUNT-1], static during search
//  busy             out  1                    high in RUN and DONE
//  search_done      out  1                    1-cycle pulse when result is valid
//  predicted_class  out  CLASS_W              index of best class
//  best_score       out  SCORE_W              overlap of best class
// BEHAVIOUR
//  Reset (nrst=0 at edge): state=IDLE; all counters, accumulators and registers = 0.
//   busy=0, search_done=0, predicted_class=0, best_score=0. Aborts any search in progress; no done pulse.
//  FSM IDLE -> RUN -> DONE -> IDLE; transitions only when en=1.
//  IDLE: start_search&en at edge T does the following:
//   - latches encoded_hv into q_reg;
//   - sets cls=0, chk=0, acc=0, run_best=0, run_idx=0;
//   - goes to RUN.
//  RUN, each enabled cycle: pc = popcount(q_reg[chk*DIMS_PER_CC +: DIMS_PER_CC] & class_hvs[cls][same slice]).
//   - chk<CHUNKS-1: acc <= acc+pc; chk++.
//   - chk==CHUNKS-1: score = acc+pc.
//     - If score > run_best (strict): run_best <= score, run_idx <= cls.
//     - acc <= 0, chk <= 0, cls++.
//   - Last chunk of cls==CLASS_COUNT-1: go to DONE.
//     - predicted_class/best_score load the final winner, including this cycle's compare.
//  DONE: search_done=1 for exactly one cycle, then go to IDLE. Outputs hold until the next DONE.
//  Latency: accepted at edge T -> search_done high in cycle T+1+CLASS_COUNT*CHUNKS, plus each en=0 cycle.
//  Ties: the lowest class index wins. An all-zero overlap reports class 0, score 0.
//  start_search while busy: ignored, not queued. start in the DONE cycle: ignored.
//  encoded_hv changes after acceptance have no effect (q_reg holds).
//  Arithmetic: acc/score are SCORE_W unsigned; no overflow is possible (max HV_DIM).
//  Elaboration check: $error if HV_DIM % DIMS_PER_CC != 0 or CLASS_COUNT < 2.
// TESTING
//  1. Reset, all-zero query, start -> done at T+1+520 (defaults); class 0, score 0; busy high 521 cycles.
//  2. Classes 0..25 disjoint, 40 bits set each; query = class_hvs[5] -> predicted 5, score 40.
//  3. Tie case: query overlaps class 3 and class 7 by 30 bits each, others by 10 -> predicted 3, score 30.
//  4. en=0 for 10 cycles mid-RUN -> done 10 cycles later; result identical to the uninterrupted run.
//  5. nrst=0 at chunk 7 of class 12 -> next cycle outputs 0, busy 0, no done; fresh start completes normally.
//  6. start pulsed during RUN and in DONE; encoded_hv changed after acceptance -> one done, first query's result.

Source files
------------

// File: rtl/am_search_if.sv
// Query/result handshake between the encoding stage and the associative-memory search.
// The master drives start and the query HV. The slave returns status and the winning class.
interface am_search_if #(
  parameter int HV_DIM      = 10000,
  parameter int CLASS_COUNT = 26,
  parameter int CLASS_W     = $clog2(CLASS_COUNT),
  parameter int SCORE_W     = $clog2(HV_DIM + 1)
);
  logic               start_search;
  logic [HV_DIM-1:0]  encoded_hv;
  logic               busy;
  logic               search_done;
  logic [CLASS_W-1:0] predicted_class;
  logic [SCORE_W-1:0] best_score;

  modport master (
    output start_search, encoded_hv,
    input  busy, search_done, predicted_class, best_score
  );

  modport slave (
    input  start_search, encoded_hv,
    output busy, search_done, predicted_class, best_score
  );
endinterface

// File: rtl/am_search.sv
// Associative-memory search: scores a latched query HV against every class HV by popcount(query & class),
// one chunk of one class per clock, and reports the best class (lowest index wins ties).
//
// state | meaning
// IDLE  | waiting for start_search; last result held on outputs
// RUN   | scoring chunk chk of class cls, accumulating into acc
// DONE  | search_done high for one cycle, then back to IDLE
module am_search #(
  parameter int HV_DIM      = 10000,
  parameter int DIMS_PER_CC = 500,
  parameter int CLASS_COUNT = 26
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic [HV_DIM-1:0] class_hvs [0:CLASS_COUNT-1],
  am_search_if.slave        bus
);
  localparam int CHUNKS  = HV_DIM / DIMS_PER_CC;
  localparam int CLASS_W = $clog2(CLASS_COUNT);
  localparam int SCORE_W = $clog2(HV_DIM + 1);
  localparam int CHK_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  if ((HV_DIM % DIMS_PER_CC) != 0 || CLASS_COUNT < 2) begin : g_param_check
    $error("am_search: HV_DIM must be a multiple of DIMS_PER_CC and CLASS_COUNT >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [HV_DIM-1:0]  q_reg;
  logic [CLASS_W-1:0] cls;
  logic [CHK_W-1:0]   chk;
  logic [SCORE_W-1:0] acc;
  logic [SCORE_W-1:0] run_best;
  logic [CLASS_W-1:0] run_idx;
  logic               busy_r;
  logic               done_r;
  logic [CLASS_W-1:0] pred_r;
  logic [SCORE_W-1:0] score_r;

  logic [DIMS_PER_CC-1:0] q_slice;
  logic [DIMS_PER_CC-1:0] c_slice;
  logic [SCORE_W-1:0]     pc;
  logic [SCORE_W-1:0]     score;
  logic                   last_chk;
  logic                   last_cls;
  logic                   better;

  assign q_slice  = q_reg[int'(chk) * DIMS_PER_CC +: DIMS_PER_CC];
  assign c_slice  = class_hvs[cls][int'(chk) * DIMS_PER_CC +: DIMS_PER_CC];
  assign pc       = SCORE_W'($countones(q_slice & c_slice));
  assign score    = acc + pc;
  assign last_chk = (chk == CHK_W'(CHUNKS - 1));
  assign last_cls = (cls == CLASS_W'(CLASS_COUNT - 1));
  // Strict compare keeps the earlier (lower-index) class on ties.
  assign better   = (score > run_best);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      q_reg    <= '0;
      cls      <= '0;
      chk      <= '0;
      acc      <= '0;
      run_best <= '0;
      run_idx  <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pred_r   <= '0;
      score_r  <= '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (bus.start_search) begin
            q_reg    <= bus.encoded_hv;
            cls      <= '0;
            chk      <= '0;
            acc      <= '0;
            run_best <= '0;
            run_idx  <= '0;
            busy_r   <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (last_chk) begin
            acc <= '0;
            chk <= '0;
            if (better) begin
              run_best <= score;
              run_idx  <= cls;
            end
            if (last_cls) begin
              // Fold this cycle's compare straight into the published result.
              pred_r  <= better ? cls : run_idx;
              score_r <= better ? score : run_best;
              done_r  <= 1'b1;
              cls     <= '0;
              state   <= DONE;
            end else begin
              cls <= cls + 1'b1;
            end
          end else begin
            acc <= score;
            chk <= chk + 1'b1;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy            = busy_r;
  assign bus.search_done     = done_r;
  assign bus.predicted_class = pred_r;
  assign bus.best_score      = score_r;
endmodule

// File: tb/tb_am_search.sv
// Self-checking bench for am_search: randomized class/query HVs scored by a direct overlap model.
module tb_am_search;
  localparam int HV_DIM      = 10000;
  localparam int DIMS_PER_CC = 500;
  localparam int CLASS_COUNT = 26;
  localparam int CHUNKS      = HV_DIM / DIMS_PER_CC;
  localparam int CLASS_W     = $clog2(CLASS_COUNT);
  localparam int SCORE_W     = $clog2(HV_DIM + 1);
  localparam int LATENCY     = 1 + CLASS_COUNT * CHUNKS;

  logic              clk = 1'b0;
  logic              nrst;
  logic              en;
  logic [HV_DIM-1:0] class_hvs [0:CLASS_COUNT-1];

  int tests_run    = 0;
  int tests_failed = 0;

  am_search_if #(.HV_DIM(HV_DIM), .CLASS_COUNT(CLASS_COUNT)) bus ();

  am_search #(
    .HV_DIM(HV_DIM), .DIMS_PER_CC(DIMS_PER_CC), .CLASS_COUNT(CLASS_COUNT)
  ) dut (
    .clk(clk), .nrst(nrst), .en(en), .class_hvs(class_hvs), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [HV_DIM-1:0] rand_hv(input int pct);
    logic [HV_DIM-1:0] v;
    v = '0;
    for (int i = 0; i < HV_DIM; i++) v[i] = (int'($urandom_range(99)) < pct);
    return v;
  endfunction

  task automatic fill_random_classes(input int pct);
    for (int k = 0; k < CLASS_COUNT; k++) class_hvs[k] = rand_hv(pct);
  endtask

  // Reference: best overlap over all classes, first maximum wins.
  task automatic model(input logic [HV_DIM-1:0] q, output int idx, output int best);
    int s;
    idx  = 0;
    best = 0;
    for (int k = 0; k < CLASS_COUNT; k++) begin
      s = $countones(q & class_hvs[k]);
      if (s > best) begin
        best = s;
        idx  = k;
      end
    end
  endtask

  task automatic launch(input logic [HV_DIM-1:0] q);
    bus.start_search = 1'b1;
    bus.encoded_hv   = q;
    step();
    bus.start_search = 1'b0;
  endtask

  // Runs from the first RUN cycle until search_done; lat is the cycle index (1-based) where done is seen.
  task automatic wait_done(input int pause_at, input int pause_len, input bit poke,
                           output int lat, output int busy_cnt, output bit timed_out);
    int n;
    n         = 1;
    busy_cnt  = 0;
    timed_out = 1'b0;
    while (1) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.search_done === 1'b1) break;
      if (n >= 3 * LATENCY) begin
        timed_out = 1'b1;
        break;
      end
      if (n == pause_at) en = 1'b0;
      if (n == pause_at + pause_len) en = 1'b1;
      if (poke && (n % 100 == 0)) begin
        bus.start_search = 1'b1;
        bus.encoded_hv   = rand_hv(50);
      end else begin
        bus.start_search = 1'b0;
      end
      step();
      n++;
    end
    en  = 1'b1;
    lat = n;
    bus.start_search = poke;
    step();
    bus.start_search = 1'b0;
  endtask

  task automatic search_and_check(input string name, input logic [HV_DIM-1:0] q,
                                  input int pause_len, input bit poke,
                                  output int got_cls, output int got_score);
    int exp_cls, exp_score, lat, busy_cnt;
    bit to;
    model(q, exp_cls, exp_score);
    launch(q);
    wait_done(200, pause_len, poke, lat, busy_cnt, to);
    tests_run++;
    if (to) begin
      tests_failed++;
      $display("FAIL %s timeout: no search_done within %0d cycles", name, 3 * LATENCY);
    end
    got_cls   = -1;
    got_score = -1;
    if (!to) begin
      got_cls   = int'(bus.predicted_class);
      got_score = int'(bus.best_score);
      tests_run++;
      if (lat !== LATENCY + pause_len) begin
        tests_failed++;
        $display("FAIL %s latency: got %0d expected %0d", name, lat, LATENCY + pause_len);
      end
      tests_run++;
      if (busy_cnt !== LATENCY + pause_len) begin
        tests_failed++;
        $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, LATENCY + pause_len);
      end
      tests_run++;
      if (got_cls !== exp_cls) begin
        tests_failed++;
        $display("FAIL %s predicted_class: got %0d expected %0d", name, got_cls, exp_cls);
      end
      tests_run++;
      if (got_score !== exp_score) begin
        tests_failed++;
        $display("FAIL %s best_score: got %0d expected %0d", name, got_score, exp_score);
      end
      tests_run++;
      if (bus.busy !== 1'b0 || bus.search_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s after_done: busy=%b done=%b expected 0/0", name, bus.busy, bus.search_done);
      end
      tests_run++;
      if (int'(bus.predicted_class) !== exp_cls || int'(bus.best_score) !== exp_score) begin
        tests_failed++;
        $display("FAIL %s hold: got %0d/%0d expected %0d/%0d", name,
                 bus.predicted_class, bus.best_score, exp_cls, exp_score);
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) step();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.search_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_status: busy=%b done=%b expected 0/0", bus.busy, bus.search_done);
    end
    tests_run++;
    if (bus.predicted_class !== '0 || bus.best_score !== '0) begin
      tests_failed++;
      $display("FAIL reset_result: got %0d/%0d expected 0/0", bus.predicted_class, bus.best_score);
    end
    nrst = 1'b1;
    step();
  endtask

  task automatic test_zero_query();
    int c, s;
    fill_random_classes(30);
    search_and_check("zero_query", '0, 0, 1'b0, c, s);
    tests_run++;
    if (c !== 0 || s !== 0) begin
      tests_failed++;
      $display("FAIL zero_query_fixed: got %0d/%0d expected 0/0", c, s);
    end
  endtask

  task automatic test_disjoint();
    int c, s;
    for (int k = 0; k < CLASS_COUNT; k++) begin
      class_hvs[k] = '0;
      for (int j = 0; j < 40; j++) class_hvs[k][k + CLASS_COUNT * j] = 1'b1;
    end
    search_and_check("disjoint", class_hvs[5], 0, 1'b0, c, s);
    tests_run++;
    if (c !== 5 || s !== 40) begin
      tests_failed++;
      $display("FAIL disjoint_fixed: got %0d/%0d expected 5/40", c, s);
    end
  endtask

  task automatic test_tie();
    logic [HV_DIM-1:0] q;
    int c, s;
    q = '0;
    for (int i = 0; i < 100; i++) q[97 * i] = 1'b1;
    for (int k = 0; k < CLASS_COUNT; k++) begin
      class_hvs[k] = rand_hv(20) & ~q;
      if (k == 3)      for (int i = 0;  i < 30; i++) class_hvs[k][97 * i] = 1'b1;
      else if (k == 7) for (int i = 60; i < 90; i++) class_hvs[k][97 * i] = 1'b1;
      else             for (int i = 0;  i < 10; i++) class_hvs[k][97 * i] = 1'b1;
    end
    search_and_check("tie", q, 0, 1'b0, c, s);
    tests_run++;
    if (c !== 3 || s !== 30) begin
      tests_failed++;
      $display("FAIL tie_fixed: got %0d/%0d expected 3/30", c, s);
    end
  endtask

  task automatic test_random();
    int c, s;
    for (int it = 0; it < 3; it++) begin
      fill_random_classes(int'($urandom_range(10, 60)));
      search_and_check("random", rand_hv(int'($urandom_range(10, 60))), 0, 1'b0, c, s);
    end
  endtask

  task automatic test_enable_pause();
    logic [HV_DIM-1:0] q;
    int c0, s0, c1, s1;
    fill_random_classes(40);
    q = rand_hv(40);
    search_and_check("pause_ref", q, 0, 1'b0, c0, s0);
    search_and_check("pause", q, 10, 1'b0, c1, s1);
    tests_run++;
    if (c1 !== c0 || s1 !== s0) begin
      tests_failed++;
      $display("FAIL pause_same_result: got %0d/%0d expected %0d/%0d", c1, s1, c0, s0);
    end
  endtask

  task automatic test_abort_reset();
    int c, s;
    bit stray;
    fill_random_classes(40);
    launch(rand_hv(40));
    // Cycle n scores chunk (n-1)%CHUNKS of class (n-1)/CHUNKS; stop at chunk 7 of class 12.
    for (int n = 1; n < 12 * CHUNKS + 8; n++) step();
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.search_done !== 1'b0 ||
        bus.predicted_class !== '0 || bus.best_score !== '0) begin
      tests_failed++;
      $display("FAIL abort_reset: busy=%b done=%b cls=%0d score=%0d expected all 0",
               bus.busy, bus.search_done, bus.predicted_class, bus.best_score);
    end
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.busy !== 1'b0 || bus.search_done !== 1'b0) stray = 1'b1;
    end
    tests_run++;
    if (stray) begin
      tests_failed++;
      $display("FAIL abort_quiet: got activity after reset expected none");
    end
    search_and_check("after_abort", rand_hv(35), 0, 1'b0, c, s);
  endtask

  task automatic test_back_to_back();
    int c, s;
    bit stray;
    fill_random_classes(45);
    search_and_check("poke", rand_hv(45), 0, 1'b1, c, s);
    stray = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.busy !== 1'b0 || bus.search_done !== 1'b0) stray = 1'b1;
    end
    tests_run++;
    if (stray) begin
      tests_failed++;
      $display("FAIL poke_no_requeue: got extra search activity expected none");
    end
  endtask

  initial begin
    nrst             = 1'b0;
    en               = 1'b1;
    bus.start_search = 1'b0;
    bus.encoded_hv   = '0;
    for (int k = 0; k < CLASS_COUNT; k++) class_hvs[k] = '0;
    test_reset();
    test_zero_query();
    test_disjoint();
    test_tie();
    test_random();
    test_enable_pause();
    test_abort_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
